rom_burst_reader: RTL and testbench

//  Client on one ROM arbiter port. On start, fetches length sequential words from base_addr.

---
 rtl/rom_burst_reader.sv | 93 +++++++++
 tb/tb_rom_burst_reader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: fetches a burst of sequential ROM words through a credit-limited FIFO onto a valid/ready stream
module rom_burst_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_accept_i,
  input  logic [DATA_WIDTH-1:0] mem_d4rd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remain;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  accept, push, pop;
  // The word granted last cycle arrives now, so the in-flight flag is exactly the push strobe.
  assign push       = inflight;
  assign pop        = ready_i & valid_o;
  assign accept     = mem_rd_o & mem_accept_i;
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign mem_rd_o   = (state == FETCH) && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
  assign mem_addr_o = addr;
  assign valid_o    = (count != '0);
  assign data_o     = valid_o ? mem[rd_ptr] : '0;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  // Next-state decode; DRAIN exits as the last word leaves so done lands right after the final pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_i ? ((length_i == '0) ? DONE : FETCH) : IDLE;
      FETCH:   state_nxt = (accept && remain == LEN_WIDTH'(1)) ? DRAIN : FETCH;
      DRAIN:   state_nxt = (count_nxt == '0 && !inflight) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end
  // Burst address/length bookkeeping and the single outstanding-read flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr     <= '0;
      remain   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (state == IDLE && start_i) begin
        addr   <= base_addr_i;
        remain <= length_i;
      end else if (accept) begin
        addr   <= addr + ADDR_WIDTH'(1);
        remain <= remain - LEN_WIDTH'(1);
      end
    end
  end
  // FIFO pointers and occupancy; storage itself needs no reset since data_o is gated by valid_o.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end
  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mem_d4rd_i;
  end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: table-driven and sequence checks of rom_burst_reader against a ROM model
module tb_rom_burst_reader;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  base_addr_i = '0;
  logic [7:0]  length_i = '0;
  logic        busy_o, done_o, mem_rd_o, valid_o;
  logic [9:0]  mem_addr_o;
  logic        mem_accept_i = 1'b0;
  logic [31:0] mem_d4rd_i = '0;
  logic [31:0] data_o;
  logic        ready_i = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic        start;
    logic [9:0]  base;
    logic [7:0]  len;
    logic [45:0] exp;
  } vec_t;
  vec_t tv [11];

  rom_burst_reader dut (
    .clk(clk), .rst_b(rst_b), .start_i(start_i), .base_addr_i(base_addr_i),
    .length_i(length_i), .busy_o(busy_o), .done_o(done_o), .mem_rd_o(mem_rd_o),
    .mem_addr_o(mem_addr_o), .mem_accept_i(mem_accept_i), .mem_d4rd_i(mem_d4rd_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [9:0] a);
    return {a, 12'hC0D, ~a};
  endfunction

  function automatic logic [45:0] pk(input logic b, input logic d, input logic r,
                                     input logic [9:0] a, input logic v, input logic [31:0] x);
    return {b, d, r, a, v, x};
  endfunction

  // ROM behind the arbiter: data for an accepted address shows up one cycle later, garbage otherwise.
  always @(posedge clk)
    mem_d4rd_i <= (mem_rd_o && mem_accept_i) ? rom_f(mem_addr_o) : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one burst with a scoreboard: address order, hold rule, data order, counts and done.
  task automatic burst(input logic [9:0] base, input logic [7:0] len, input int acc_mode,
                       input int rdy_rand, input int hold, input string name);
    int popped = 0;
    int accepts = 0;
    int cyc = 0;
    bit done_seen = 0;
    logic prev_stall = 0;
    logic [9:0] prev_addr = '0;
    logic [9:0] ea;
    start_i = 1'b1; base_addr_i = base; length_i = len;
    mem_accept_i = 1'b0; ready_i = 1'b0;
    step;
    start_i = 1'b0;
    while (!done_seen && cyc < 300) begin
      mem_accept_i = (acc_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      ready_i = (cyc < hold) ? 1'b0 : (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall) chk({name, " hold"}, {mem_rd_o, mem_addr_o}, {1'b1, prev_addr});
      if (mem_rd_o && mem_accept_i) begin
        ea = base + 10'(accepts);
        chk({name, " addr"}, mem_addr_o, ea);
        accepts++;
      end
      if (valid_o && ready_i) begin
        ea = base + 10'(popped);
        chk({name, " data"}, data_o, rom_f(ea));
        popped++;
      end
      if (hold > 0 && cyc == hold - 1)
        chk({name, " credit"}, {32'(accepts), mem_rd_o, valid_o}, {32'd4, 1'b0, 1'b1});
      if (done_o) done_seen = 1;
      prev_stall = mem_rd_o && !mem_accept_i;
      prev_addr = mem_addr_o;
      step;
      cyc++;
    end
    chk({name, " done"}, {31'd0, done_seen}, 64'd1);
    chk({name, " counts"}, {32'(popped), 32'(accepts)}, {32'(len), 32'(len)});
    chk({name, " idle"}, {busy_o, done_o, valid_o}, 3'b000);
    mem_accept_i = 1'b0; ready_i = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 10'h010, 8'd4, pk(0, 0, 0, 10'h000, 0, 32'h0)};
    tv[1]  = '{1'b0, 10'h000, 8'd0, pk(1, 0, 1, 10'h010, 0, 32'h0)};
    tv[2]  = '{1'b0, 10'h000, 8'd0, pk(1, 0, 1, 10'h011, 0, 32'h0)};
    tv[3]  = '{1'b0, 10'h000, 8'd0, pk(1, 0, 1, 10'h012, 1, rom_f(10'h010))};
    tv[4]  = '{1'b0, 10'h000, 8'd0, pk(1, 0, 1, 10'h013, 1, rom_f(10'h011))};
    tv[5]  = '{1'b0, 10'h000, 8'd0, pk(1, 0, 0, 10'h014, 1, rom_f(10'h012))};
    tv[6]  = '{1'b0, 10'h000, 8'd0, pk(1, 0, 0, 10'h014, 1, rom_f(10'h013))};
    tv[7]  = '{1'b0, 10'h000, 8'd0, pk(1, 1, 0, 10'h014, 0, 32'h0)};
    tv[8]  = '{1'b1, 10'h100, 8'd0, pk(0, 0, 0, 10'h014, 0, 32'h0)};
    tv[9]  = '{1'b0, 10'h000, 8'd0, pk(1, 1, 0, 10'h100, 0, 32'h0)};
    tv[10] = '{1'b0, 10'h000, 8'd0, pk(0, 0, 0, 10'h100, 0, 32'h0)};
    repeat (3) step;
    chk("reset", pk(busy_o, done_o, mem_rd_o, mem_addr_o, valid_o, data_o), 46'h0);
    rst_b = 1'b1;
    step;
    mem_accept_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      start_i = tv[i].start; base_addr_i = tv[i].base; length_i = tv[i].len;
      #1;
      chk($sformatf("t1t2 row%0d", i),
          pk(busy_o, done_o, mem_rd_o, mem_addr_o, valid_o, tv[i].exp[32] ? data_o : 32'h0),
          tv[i].exp);
      step;
    end
    start_i = 1'b0;
    burst(10'h3FE, 8'd4, 0, 0, 0, "t3 wrap");
    burst(10'h080, 8'd10, 0, 0, 12, "t4 backpressure");
    burst(10'h1F8, 8'd10, 1, 1, 0, "t5 toggle");
    start_i = 1'b1; base_addr_i = 10'h020; length_i = 8'd8;
    mem_accept_i = 1'b1; ready_i = 1'b0;
    step;
    start_i = 1'b0;
    step;
    step;
    mem_accept_i = 1'b0;
    step;
    #1;
    chk("t6 buffered", {busy_o, mem_rd_o, valid_o, data_o}, {3'b111, rom_f(10'h020)});
    #2 rst_b = 1'b0;
    #1;
    chk("t6 async reset", pk(busy_o, done_o, mem_rd_o, mem_addr_o, valid_o, data_o), 46'h0);
    step;
    step;
    chk("t6 held reset", pk(busy_o, done_o, mem_rd_o, mem_addr_o, valid_o, data_o), 46'h0);
    #2 rst_b = 1'b1;
    step;
    chk("t6 after release", {busy_o, done_o, valid_o}, 3'b000);
    burst(10'h040, 8'd3, 0, 0, 0, "t6 restart");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
